// File: rtl/synchronous_fifo_ext.sv
// Synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, flush, and optional FWFT read.
module synchronous_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic                         flush,
    input  logic                         clr_err,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_q;
    logic [ADDR_W-1:0]     wr_idx;
    logic [ADDR_W-1:0]     rd_idx;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    // Status is decoded from the registered count, so qualification below
    // always sees the pre-edge occupancy.
    assign count        = count_q;
    assign full         = (count_q == PTR_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= PTR_W'(AF_LEVEL));
    assign almost_empty = (count_q <= PTR_W'(AE_LEVEL));

    assign wr_ok = w_en & ~full;
    assign rd_ok = r_en & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + PTR_W'(1);
                2'b01:   count_q <= count_q - PTR_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_ok) mem[wr_idx] <= data_in;
    end

    // Set has priority over clear; flush leaves the flags untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            overflow  <= (w_en & full)  | (overflow  & ~clr_err);
            underflow <= (r_en & empty) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem[rd_idx];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst_n)              dout_q <= '0;
                else if (!flush && rd_ok) dout_q <= mem[rd_idx];
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_synchronous_fifo_ext.sv
// Directed bench for synchronous_fifo_ext: standard-mode instance plus an FWFT instance.
module tb_synchronous_fifo_ext;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_en, r_en, flush, clr_err;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_w_en, f_r_en, f_flush, f_clr_err;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    synchronous_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    synchronous_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(f_w_en), .r_en(f_r_en), .flush(f_flush), .clr_err(f_clr_err),
        .data_in(f_data_in), .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the standard instance; outputs sampled 1ns after the edge.
    task automatic step(input logic w, input logic r, input logic fl, input logic ce, input logic [7:0] d);
        w_en = w; r_en = r; flush = fl; clr_err = ce; data_in = d;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic fstep(input logic w, input logic r, input logic [7:0] d);
        f_w_en = w; f_r_en = r; f_data_in = d;
        @(posedge clk);
        #1;
        f_w_en = 1'b0; f_r_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_udf"}, underflow, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
        f_w_en = 1'b0; f_r_en = 1'b0; f_flush = 1'b0; f_clr_err = 1'b0; f_data_in = '0;

        // Reset, with a write request asserted to confirm reset priority
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        chk_reset_state("rst");
        chk("rst_fwft_empty", f_empty, 1);

        // Fill 0x00..0x0F with threshold checks on the way up
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            if (i == 1)  chk("fill_c2_ae", almost_empty, 1);
            if (i == 2)  chk("fill_c3_ae", almost_empty, 0);
            if (i == 12) chk("fill_c13_af", almost_full, 0);
            if (i == 13) chk("fill_c14_af", almost_full, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_dout_held", data_out, 0);

        // Extra write when full
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);

        // Drain: each word appears the edge its read is accepted
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("drain_%0d", i), data_out, 32'(i));
            if (i == 2)  chk("drain_c13_af", almost_full, 0);
            if (i == 12) chk("drain_c3_ae", almost_empty, 0);
            if (i == 13) chk("drain_c2_ae", almost_empty, 1);
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Read when empty
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("udf_flag", underflow, 1);
        chk("udf_dout_held", data_out, 8'h0F);
        chk("udf_ovf_sticky", overflow, 1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);

        // Simultaneous read/write at count 0: only the write is accepted
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("rw0_count", count, 1);
        chk("rw0_udf", underflow, 1);
        chk("rw0_dout_held", data_out, 8'h0F);

        // Set wins over clear
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("clr_read_dout", data_out, 8'h55);
        chk("clr_udf_cleared", underflow, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("set_wins_udf", underflow, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_again", underflow, 0);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
        chk("rw5_pre", count, 5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h15);
        chk("rw5_count", count, 5);
        chk("rw5_dout", data_out, 8'h10);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("rw5_order_%0d", i), data_out, 32'(8'h11 + i));
        end
        chk("rw5_empty", empty, 1);

        // Flush at count 9 (w_en asserted too, flush wins)
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
        chk("flush_pre", count, 9);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hCC);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_dout_held", data_out, 8'h15);

        // Refill, then reset mid-operation with requests asserted
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("refill_dout", data_out, 8'h30);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        chk("refill_count", count, 3);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        rst_n = 1'b1;
        chk_reset_state("midrst");

        // Wrap-around: 43 writes, steady occupancy of 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int j = 0; j < 40; j++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h43 + j));
            chk($sformatf("wrap_%0d", j), data_out, 32'(8'(8'h40 + j)));
        end
        chk("wrap_count", count, 3);

        // FWFT instance
        fstep(1'b1, 1'b0, 8'hA5);
        chk("fwft_dout", f_data_out, 8'hA5);
        chk("fwft_notempty", f_empty, 0);
        fstep(1'b0, 1'b0, 8'h00);
        chk("fwft_hold", f_data_out, 8'hA5);
        fstep(1'b0, 1'b1, 8'h00);
        chk("fwft_pop_empty", f_empty, 1);
        fstep(1'b1, 1'b0, 8'h11);
        fstep(1'b1, 1'b0, 8'h22);
        chk("fwft_head1", f_data_out, 8'h11);
        chk("fwft_count2", f_count, 2);
        fstep(1'b0, 1'b1, 8'h00);
        chk("fwft_head2", f_data_out, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
